// File: rtl/nn_stream_pkg.sv
// -----------------------------------------------------------------------------
// nn_stream_pkg
// Shared definitions for the inter-layer activation stream. Both the
// transmitting connector and the receiving distributor use these definitions.
//   ACT_W        : width of one activation word
//   L1_WORDS     : activation words per layer-1 frame
//   dist_state_t : receiver state (FILL = collecting words, HOLD = vector
//                  presented downstream and waiting for the consume pulse)
// -----------------------------------------------------------------------------
package nn_stream_pkg;

   localparam int ACT_W    = 32;
   localparam int L1_WORDS = 18;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } dist_state_t;

endpackage : nn_stream_pkg

// File: rtl/axis_layer_distributor.sv
// -----------------------------------------------------------------------------
// axis_layer_distributor
// Receiving end of the inter-layer AXI4-Stream link. Serial activation words
// are deserialized into N_WORDS parallel registers. The complete vector is
// presented with a_valid and held until the downstream array pulses
// a_consumed.
//
// Ports
//   clk        : system clock, rising edge
//   resetn     : asynchronous active-low reset (release synchronous to clk)
//   s_tdata    : stream data word
//   s_tvalid   : stream word valid
//   s_tready   : block can accept a word (registered, depends only on state)
//   s_tlast    : final word of a frame
//   a_flat     : deserialized vector, word i at [i*DATA_W +: DATA_W]
//   a_valid    : a_flat holds a complete frame
//   a_consumed : downstream has latched the vector, release the buffer
//   frame_err  : sticky framing error flag (cleared only by reset)
// -----------------------------------------------------------------------------
module axis_layer_distributor
   import nn_stream_pkg::*;
#(
   parameter int N_WORDS = L1_WORDS,
   parameter int DATA_W  = ACT_W,
   parameter int IDX_W   = $clog2(N_WORDS)
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [DATA_W-1:0]           s_tdata,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   input  logic                        s_tlast,
   output logic [N_WORDS*DATA_W-1:0]   a_flat,
   output logic                        a_valid,
   input  logic                        a_consumed,
   output logic                        frame_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   dist_state_t       state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic              ready_reg, ready_next;
   logic              err_reg, err_next;
   logic              handshake;

   logic [DATA_W-1:0] word_reg [N_WORDS];

   // ready_reg is only ever 1 in FILL, so the handshake needs no state term.
   assign handshake = s_tvalid & ready_reg;

   // -------------------------------------------------------------------------
   // FSM and index counter: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      err_next   = err_reg;

      case (state_reg)
         FILL: begin
            if (handshake) begin
               if (idx_reg == LAST_IDX) begin
                  // Full frame collected; a missing tlast is flagged but the
                  // frame is still delivered.
                  idx_next   = '0;
                  state_next = HOLD;
                  if (!s_tlast) begin
                     err_next = 1'b1;
                  end
               end else if (s_tlast) begin
                  // Early tlast: drop the partial frame and restart at word 0.
                  // Words already written stay in the bank until overwritten.
                  idx_next = '0;
                  err_next = 1'b1;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end
         end
         HOLD: begin
            if (a_consumed) begin
               state_next = FILL;
            end
         end
         default: begin
            state_next = FILL;
            idx_next   = '0;
         end
      endcase

      // Ready is registered from the next state so it tracks the state
      // register exactly and never depends combinationally on s_tvalid.
      ready_next = (state_next == FILL);
   end

   // -------------------------------------------------------------------------
   // FSM and index counter: state registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= FILL;
         idx_reg   <= '0;
         ready_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         ready_reg <= ready_next;
         err_reg   <= err_next;
      end
   end

   // -------------------------------------------------------------------------
   // Register bank: one word per index, written on a handshake at that index
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               word_reg[gi] <= '0;
            end else if (handshake && (idx_reg == IDX_W'(gi))) begin
               word_reg[gi] <= s_tdata;
            end
         end

         assign a_flat[gi*DATA_W +: DATA_W] = word_reg[gi];
      end
   endgenerate

   assign s_tready  = ready_reg;
   assign a_valid   = (state_reg == HOLD);
   assign frame_err = err_reg;

endmodule : axis_layer_distributor

// File: tb/tb_axis_layer_distributor.sv
// -----------------------------------------------------------------------------
// tb_axis_layer_distributor
// Directed bench for axis_layer_distributor. Expected frames are pushed onto
// a scoreboard queue as they are streamed in and popped when the DUT raises
// a_valid. Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_axis_layer_distributor;

   localparam int N = 18;
   localparam int W = 32;

   typedef logic [N*W-1:0] vec_t;

   logic          clk;
   logic          resetn;
   logic [W-1:0]  s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   vec_t          a_flat;
   logic          a_valid;
   logic          a_consumed;
   logic          frame_err;

   int            n_tests = 0;
   int            n_fail  = 0;
   longint        cyc     = 0;
   vec_t          sb_q[$];

   axis_layer_distributor #(
      .N_WORDS (N),
      .DATA_W  (W)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .s_tlast    (s_tlast),
      .a_flat     (a_flat),
      .a_valid    (a_valid),
      .a_consumed (a_consumed),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic vec_t mkvec(input int base);
      vec_t v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         v[i*W +: W] = W'(base + i);
      end
      return v;
   endfunction

   function automatic logic [W-1:0] word_of(input vec_t v, input int i);
      return v[i*W +: W];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word and keep it until the DUT takes it (bounded wait).
   task automatic send_word(input logic [W-1:0] d, input logic last, input bit gaps);
      int waited;
      bit hs;
      waited = 0;
      hs     = 1'b0;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         s_tvalid = 1'b0;
         step();
      end
      s_tdata  = d;
      s_tlast  = last;
      s_tvalid = 1'b1;
      do begin
         hs = s_tready;
         step();
         waited++;
      end while (!hs && waited < 50);
      if (!hs) chk("handshake_timeout", 64'(hs), 64'd1);
   endtask

   // Stream words base..base+len-1, tlast at last_pos (-1 for none).
   task automatic send_frame(input int base, input int len, input int last_pos,
                             input bit gaps, input bit deliver, output longint cycles);
      longint start;
      start = cyc;
      for (int i = 0; i < len; i++) begin
         if (deliver && i == len - 1) begin
            chk("a_valid_before_last", 64'(a_valid), 64'd0);
         end
         send_word(W'(base + i), (i == last_pos), gaps);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      cycles   = cyc - start;
   endtask

   task automatic check_delivery(input string tag);
      vec_t exp;
      chk({tag, "_a_valid"}, 64'(a_valid), 64'd1);
      chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
      if (sb_q.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
      end else begin
         exp = sb_q.pop_front();
         chk_vec({tag, "_a_flat"}, a_flat, exp);
      end
      $display("[TB] frame %s delivered at cycle %0d", tag, cyc);
   endtask

   task automatic consume(input string tag);
      s_tvalid   = 1'b0;
      a_consumed = 1'b1;
      step();
      a_consumed = 1'b0;
      chk({tag, "_consume_a_valid"}, 64'(a_valid), 64'd0);
      chk({tag, "_consume_s_tready"}, 64'(s_tready), 64'd1);
   endtask

   initial begin
      longint cycles;

      resetn     = 1'b0;
      s_tdata    = '0;
      s_tvalid   = 1'b0;
      s_tlast    = 1'b0;
      a_consumed = 1'b0;
      step();
      step();

      // Reset state
      chk_vec("rst_a_flat", a_flat, '0);
      chk("rst_a_valid", 64'(a_valid), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      resetn = 1'b1;
      step();
      chk("post_rst_s_tready", 64'(s_tready), 64'd1);

      // Back-to-back frame 0..17
      sb_q.push_back(mkvec(0));
      send_frame(0, N, N - 1, 1'b0, 1'b1, cycles);
      chk("b2b_accept_cycles", 64'(cycles), 64'(N));
      check_delivery("b2b");
      chk("b2b_frame_err", 64'(frame_err), 64'd0);
      chk("b2b_word17", 64'(word_of(a_flat, 17)), 64'd17);

      // HOLD must ignore a valid word for 10 cycles
      s_tdata  = 32'd99;
      s_tvalid = 1'b1;
      repeat (10) step();
      chk_vec("hold_a_flat_stable", a_flat, mkvec(0));
      chk("hold_s_tready", 64'(s_tready), 64'd0);
      chk("hold_a_valid", 64'(a_valid), 64'd1);
      consume("hold");

      // Second frame 100..117
      sb_q.push_back(mkvec(100));
      send_frame(100, N, N - 1, 1'b0, 1'b1, cycles);
      check_delivery("second");
      chk("second_word0", 64'(word_of(a_flat, 0)), 64'd100);
      consume("second");

      // Random valid gaps give the same vector
      sb_q.push_back(mkvec(0));
      send_frame(0, N, N - 1, 1'b1, 1'b1, cycles);
      check_delivery("gaps");
      consume("gaps");

      // Missing tlast on the final word: delivered, error on the same edge
      chk("pre_notlast_frame_err", 64'(frame_err), 64'd0);
      sb_q.push_back(mkvec(0));
      send_frame(0, N, -1, 1'b0, 1'b1, cycles);
      chk("notlast_frame_err", 64'(frame_err), 64'd1);
      check_delivery("notlast");
      consume("notlast");

      // Reset in the middle of a frame (after word 9)
      send_frame(0, 10, -1, 1'b0, 1'b0, cycles);
      resetn = 1'b0;
      #1;
      chk_vec("midrst_a_flat", a_flat, '0);
      chk("midrst_a_valid", 64'(a_valid), 64'd0);
      chk("midrst_frame_err", 64'(frame_err), 64'd0);
      chk("midrst_s_tready", 64'(s_tready), 64'd0);
      step();
      resetn = 1'b1;
      step();
      chk("midrst_release_s_tready", 64'(s_tready), 64'd1);
      sb_q.push_back(mkvec(0));
      send_frame(0, N, N - 1, 1'b0, 1'b1, cycles);
      check_delivery("after_rst");
      consume("after_rst");

      // Early tlast on word 5, then a full frame 20..37
      send_frame(0, 6, 5, 1'b0, 1'b0, cycles);
      chk("early_frame_err", 64'(frame_err), 64'd1);
      chk("early_a_valid", 64'(a_valid), 64'd0);
      chk("early_s_tready", 64'(s_tready), 64'd1);
      sb_q.push_back(mkvec(20));
      send_frame(20, N, N - 1, 1'b0, 1'b1, cycles);
      check_delivery("after_early");
      chk("after_early_word0", 64'(word_of(a_flat, 0)), 64'd20);
      chk("after_early_word17", 64'(word_of(a_flat, 17)), 64'd37);
      chk("after_early_frame_err", 64'(frame_err), 64'd1);
      consume("after_early");

      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_axis_layer_distributor
